// File: rtl/sp_ram_responder.sv
// sp_ram_responder: single-port RAM responder with byte-masked writes,
// pipelined reads of configurable latency, read-valid strobe and range error.
module sp_ram_responder #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 4096,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  input  logic                oe,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] W_req,
  input  logic [DATA_W-1:0]   W_data,
  output logic [DATA_W-1:0]   R_data,
  output logic                rvalid_o,
  output logic                err_o
);
  localparam int NB = DATA_W / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

  if (DATA_W % 8 != 0 || READ_LAT < 1 || READ_LAT > 3 || DEPTH > 2 ** ADDR_W) begin : g_bad_param
    $error("sp_ram_responder: illegal DATA_W/READ_LAT/DEPTH");
  end

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_pipe [READ_LAT];
  logic [READ_LAT-1:0] r_pvld;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err_d;
  logic                w_in;
  logic                w_rd;
  logic                w_wr;
  logic [IW-1:0]       w_idx;

  assign w_in   = {1'b0, addr} < (ADDR_W + 1)'(DEPTH);
  assign w_rd   = cs && &W_req;
  assign w_wr   = cs && !(&W_req) && w_in;
  assign w_idx  = addr[IW-1:0];
  assign R_data = oe ? r_rdata : '0;

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (w_wr && !W_req[b]) r_mem[w_idx][8*b +: 8] <= W_data[8*b +: 8];
  end

  // The array is sampled at acceptance, so later writes never alter a read in flight.
  always_ff @(posedge clk) begin
    if (w_rd) r_pipe[0] <= w_in ? r_mem[w_idx] : '0;
    for (int k = 1; k < READ_LAT; k++) r_pipe[k] <= r_pipe[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pvld   <= '0;
      r_rdata  <= '0;
      rvalid_o <= 1'b0;
      r_err_d  <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      r_pvld[0] <= w_rd;
      for (int k = 1; k < READ_LAT; k++) r_pvld[k] <= r_pvld[k-1];
      if (r_pvld[READ_LAT-1]) r_rdata <= r_pipe[READ_LAT-1];
      rvalid_o <= r_pvld[READ_LAT-1];
      r_err_d  <= cs && !w_in;
      err_o    <= r_err_d;
    end
  end
endmodule

// File: tb/tb_sp_ram_responder.sv
// tb_sp_ram_responder: table-driven checks on a READ_LAT=1 instance plus
// directed multi-cycle sequences on READ_LAT=3 and READ_LAT=2 instances.
module tb_sp_ram_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        oe = 1'b1;
  logic [15:0] addr = '0;
  logic [3:0]  wreq = 4'hF;
  logic [31:0] wdata = '0;
  logic [31:0] r1, r2, r3;
  logic        v1, v2, v3, e1, e2, e3;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sp_ram_responder #(.READ_LAT(1)) u1 (.clk(clk), .rst(rst), .cs(cs), .oe(oe), .addr(addr),
    .W_req(wreq), .W_data(wdata), .R_data(r1), .rvalid_o(v1), .err_o(e1));
  sp_ram_responder #(.READ_LAT(2)) u2 (.clk(clk), .rst(rst), .cs(cs), .oe(oe), .addr(addr),
    .W_req(wreq), .W_data(wdata), .R_data(r2), .rvalid_o(v2), .err_o(e2));
  sp_ram_responder #(.READ_LAT(3)) u3 (.clk(clk), .rst(rst), .cs(cs), .oe(oe), .addr(addr),
    .W_req(wreq), .W_data(wdata), .R_data(r3), .rvalid_o(v3), .err_o(e3));

  typedef struct {
    logic        c;
    logic        o;
    logic [15:0] a;
    logic [3:0]  w;
    logic [31:0] d;
    logic [31:0] er;
    logic        ev;
    logic        ee;
  } vec_t;

  vec_t tv[19];

  task automatic step(input logic c, input logic o, input logic [15:0] a, input logic [3:0] w,
                      input logic [31:0] d);
    @(negedge clk);
    cs = c; oe = o; addr = a; wreq = w; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  initial begin
    // Each row's expectation is the registered result of the previous row's access.
    tv[0]  = '{1'b1, 1'b1, 16'd0,    4'h0, 32'hA0,       32'h0,        1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 16'd1,    4'h0, 32'hA1,       32'h0,        1'b0, 1'b0};
    tv[2]  = '{1'b1, 1'b1, 16'd2,    4'h0, 32'hA2,       32'h0,        1'b0, 1'b0};
    tv[3]  = '{1'b1, 1'b1, 16'd3,    4'h0, 32'hA3,       32'h0,        1'b0, 1'b0};
    tv[4]  = '{1'b1, 1'b1, 16'd5,    4'h0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    tv[5]  = '{1'b1, 1'b1, 16'd5,    4'hF, 32'h0,        32'h0,        1'b0, 1'b0};
    tv[6]  = '{1'b0, 1'b1, 16'd0,    4'hF, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    tv[7]  = '{1'b1, 1'b1, 16'd5,    4'hA, 32'h11223344, 32'hDEADBEEF, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 1'b1, 16'd5,    4'hF, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 1'b1, 16'd0,    4'hF, 32'h0,        32'hDE22BE44, 1'b1, 1'b0};
    tv[10] = '{1'b1, 1'b1, 16'd4096, 4'h0, 32'h55,       32'hDE22BE44, 1'b0, 1'b0};
    tv[11] = '{1'b0, 1'b1, 16'd0,    4'hF, 32'h0,        32'hDE22BE44, 1'b0, 1'b1};
    tv[12] = '{1'b1, 1'b1, 16'd4096, 4'hF, 32'h0,        32'hDE22BE44, 1'b0, 1'b0};
    tv[13] = '{1'b1, 1'b1, 16'd0,    4'hF, 32'h0,        32'h0,        1'b1, 1'b1};
    tv[14] = '{1'b0, 1'b0, 16'd0,    4'hF, 32'h0,        32'h0,        1'b1, 1'b0};
    tv[15] = '{1'b0, 1'b1, 16'd0,    4'hF, 32'h0,        32'hA0,       1'b0, 1'b0};
    tv[16] = '{1'b0, 1'b1, 16'd3,    4'h0, 32'hFF,       32'hA0,       1'b0, 1'b0};
    tv[17] = '{1'b1, 1'b1, 16'd3,    4'hF, 32'h0,        32'hA0,       1'b0, 1'b0};
    tv[18] = '{1'b0, 1'b1, 16'd0,    4'hF, 32'h0,        32'hA3,       1'b1, 1'b0};

    step(1'b0, 1'b1, 16'd0, 4'hF, 32'h0);
    step(1'b0, 1'b1, 16'd0, 4'hF, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 16'(i), 4'h0, 32'hFFFF_FFFF);
      chk("idle_rdata_l1", r1, 32'h0);
      chk("idle_rdata_l3", r3, 32'h0);
      chk("idle_rvalid", {29'h0, v1, v2, v3}, 32'h0);
      chk("idle_err", {29'h0, e1, e2, e3}, 32'h0);
    end

    for (int i = 0; i < 19; i++) begin
      step(tv[i].c, tv[i].o, tv[i].a, tv[i].w, tv[i].d);
      chk($sformatf("vec%0d_rdata", i), r1, tv[i].er);
      chk($sformatf("vec%0d_rvalid", i), {31'h0, v1}, {31'h0, tv[i].ev});
      chk($sformatf("vec%0d_err", i), {31'h0, e1}, {31'h0, tv[i].ee});
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'd0, 4'hF, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step(i < 4, 1'b1, 16'(i), 4'hF, 32'h0);
      chk($sformatf("stream%0d_rvalid", i), {31'h0, v3}, {31'h0, i >= 3 && i <= 6});
      chk($sformatf("stream%0d_rdata", i), r3, i < 3 ? 32'hA3 : 32'hA0 + 32'(i > 6 ? 3 : i - 3));
    end

    for (int i = 0; i < 6; i++) begin
      step(i < 3, 1'b1, 16'd2, i == 1 ? 4'h0 : 4'hF, 32'h77);
      if (i == 3) begin
        chk("inflight_old_rvalid", {31'h0, v3}, 32'h1);
        chk("inflight_old_rdata", r3, 32'hA2);
      end
      if (i == 4) chk("inflight_gap_rvalid", {31'h0, v3}, 32'h0);
      if (i == 5) chk("inflight_new_rdata", r3, 32'h77);
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'd0, 4'hF, 32'h0);
    step(1'b1, 1'b1, 16'd5, 4'hF, 32'h0);
    rst = 1'b1;
    step(1'b0, 1'b1, 16'd0, 4'hF, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 16'd0, 4'hF, 32'h0);
      chk("rstmid_rvalid", {31'h0, v2}, 32'h0);
      chk("rstmid_rdata", r2, 32'h0);
    end

    step(1'b1, 1'b0, 16'd7, 4'h0, 32'h1234);
    step(1'b1, 1'b0, 16'd7, 4'hF, 32'h0);
    step(1'b0, 1'b0, 16'd0, 4'hF, 32'h0);
    chk("oe_wait_rvalid", {31'h0, v2}, 32'h0);
    step(1'b0, 1'b0, 16'd0, 4'hF, 32'h0);
    chk("oe_low_rvalid", {31'h0, v2}, 32'h1);
    chk("oe_low_rdata", r2, 32'h0);
    #2 oe = 1'b1;
    #1 chk("oe_rise_rdata", r2, 32'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sp_ram_responder.md
Name: sp_ram_responder

Overview:
- Memory-end responder of the single-port RAM interface: accepts cs/oe/addr/W_req/W_data from a compute-side master and returns R_data.
- Serves as the behavioural/synthesizable body behind the EPU input and output buffers.
- The same block instantiates on either side of the in/out buffer swap, so the compute side sees identical timing on both buffers.
- Adds configurable read latency, per-byte write masking, a read-valid strobe and out-of-range detection.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 16, word-address width.
- DEPTH, 4096, number of words implemented; DEPTH <= 2**ADDR_W.
- READ_LAT, 1, cycles from read acceptance to R_data update; legal range 1..3.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cs  input  1  chip select; 1 = access this cycle.
- oe  input  1  output enable; gates R_data combinationally.
- addr  input  ADDR_W  word address.
- W_req  input  DATA_W/8  per-byte write request, active-low; all-ones = read.
- W_data  input  DATA_W  write data.
- R_data  output  DATA_W  read data; equals rdata_q when oe=1, else 0.
- rvalid_o  output  1  one-cycle pulse when rdata_q is updated by a completed read.
- err_o  output  1  one-cycle pulse, registered, one cycle after an out-of-range access.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rdata_q=0, rvalid_o=0, err_o=0; read pipeline valid bits cleared.
  - Memory array is NOT cleared.
  - A read in flight when reset asserts is discarded and produces no rvalid_o.
- Access decode, sampled at the rising edge with cs=1:
  - Write when any W_req bit is 0: each byte i with W_req[i]=0 is written from W_data[8i+7:8i]; bytes with W_req[i]=1 are unchanged.
  - Read when W_req is all ones.
  - cs=0: no access; addr, W_req and W_data are ignored.
- Read latency:
  - A read accepted at edge t updates rdata_q with mem[addr] at edge t+READ_LAT.
  - rvalid_o is high for the cycle following that edge.
  - rdata_q holds its value until the next completed read; writes never change rdata_q.
- Pipelining:
  - One new read may be accepted every cycle; reads complete in order.
  - With READ_LAT=3, three reads are in flight at once.
- Write-then-read:
  - A write at edge t followed by a read of the same address at edge t+1 returns the newly written data (write-first array).
  - A read already in flight when a later write to the same address lands returns the pre-write data, because the array is read at acceptance.
- Out of range (addr >= DEPTH) with cs=1:
  - A write is dropped and the array is unchanged.
  - A read completes normally in timing (rvalid_o pulses) with data 0.
  - err_o pulses at edge t+1 for either access type.
- oe:
  - Affects only the output mux, never acceptance or rvalid_o.
  - Toggling oe mid-stream shows or hides the held rdata_q with no cycle delay.
- Parameter checks: an elaboration-time assertion fires if DATA_W%8 != 0, READ_LAT is outside 1..3, or DEPTH > 2**ADDR_W.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 2 cycles, cs=0.
  - Required: R_data=0, rvalid_o=0 and err_o=0 for 10 cycles.
- Full write then read (READ_LAT=1):
  - Stimulus: write 0xDEADBEEF to addr 5 with W_req=0000, then read addr 5.
  - Required: rvalid_o pulses 1 cycle after read acceptance; R_data=0xDEADBEEF with oe=1.
- Byte mask:
  - Stimulus: addr 5 holds 0xDEADBEEF; write 0x11223344 with W_req=1010, then read addr 5.
  - Required: R_data=0xDE22BE44.
- Streaming reads (READ_LAT=3):
  - Stimulus: addrs 0..3 hold 0xA0..0xA3; issue back-to-back reads of 0..3.
  - Required: 4 consecutive rvalid_o pulses starting 3 cycles after the first read; data 0xA0, 0xA1, 0xA2, 0xA3 in order.
- Out of range (DEPTH=4096):
  - Stimulus: write 0x55 to addr 4096, then read addr 4096.
  - Required: err_o pulses after each access; the read returns 0; addr 0 is unchanged.
- Reset mid-read and oe gating (READ_LAT=2):
  - Stimulus: issue a read, assert rst on the next cycle.
  - Required: no rvalid_o; R_data=0.
  - Stimulus: complete a read of value 0x1234 with oe=0, then raise oe.
  - Required: R_data is 0 while oe=0 and becomes 0x1234 in the same cycle oe rises.
